// File: rtl/sc_dmem_arbiter_if.sv
// rtl/sc_dmem_arbiter_if.sv - request/ack and memory-port bundle for the data memory arbiter
interface sc_dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req0;
    logic          req1;
    logic          we0;
    logic          we1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          lock0;
    logic          lock1;
    logic          ack0;
    logic          ack1;
    logic [DW-1:0] rdata0;
    logic [DW-1:0] rdata1;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;
    logic          owner;

    // requesters and the memory device
    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock0, lock1, mem_rdata,
        input  ack0, ack1, rdata0, rdata1, mem_en, mem_we, mem_addr, mem_wdata, busy, owner
    );

    // the arbiter
    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock0, lock1, mem_rdata,
        output ack0, ack1, rdata0, rdata1, mem_en, mem_we, mem_addr, mem_wdata, busy, owner
    );
endinterface

// File: rtl/sc_dmem_arbiter.sv
// rtl/sc_dmem_arbiter.sv - two-port round-robin data memory arbiter; ownership lock enabled by SC_DMEM_ARB_LOCK_EN
module sc_dmem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MEM_LAT  = 1,
    parameter int LOCK_MAX = 16
) (
    input  logic             clock,
    input  logic             resetn,
    sc_dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [2:0] LAT = 3'(MEM_LAT);

    state_t        state;
    state_t        state_nxt;
    logic          sel;
    logic          we_l;
    logic          prio;
    logic [AW-1:0] addr_l;
    logic [DW-1:0] wdata_l;
    logic [2:0]    cnt;
    logic [DW-1:0] rdata0_q;
    logic [DW-1:0] rdata1_q;
    logic          elig0;
    logic          elig1;
    logic          grant_any;
    logic          grant_sel;

`ifdef SC_DMEM_ARB_LOCK_EN
    localparam logic [7:0] LMAX = 8'(LOCK_MAX);

    logic          locked;
    logic [7:0]    lock_cnt;
    logic          lock_sel;

    assign lock_sel = sel ? bus.lock1 : bus.lock0;
`else
    logic          unused_lock;

    assign unused_lock = bus.lock0 ^ bus.lock1;
`endif

    // eligibility and winner selection for the IDLE cycle
    always_comb begin
        elig0 = bus.req0;
        elig1 = bus.req1;
`ifdef SC_DMEM_ARB_LOCK_EN
        // while locked only the owning master may be granted
        if (locked) begin
            elig0 = bus.req0 && !sel;
            elig1 = bus.req1 && sel;
        end
`endif
        grant_any = elig0 | elig1;
        grant_sel = (elig0 && elig1) ? prio : elig1;
    end

    // state register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_any) state_nxt = ISSUE;
            ISSUE:   state_nxt = we_l ? DONE : WAIT;
            WAIT:    if (cnt == 3'd1) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // transaction latches, priority pointer, read-data capture and lock tracking
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sel      <= 1'b0;
            we_l     <= 1'b0;
            prio     <= 1'b0;
            addr_l   <= '0;
            wdata_l  <= '0;
            cnt      <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
`ifdef SC_DMEM_ARB_LOCK_EN
            locked   <= 1'b0;
            lock_cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        sel  <= grant_sel;
                        prio <= ~grant_sel;
                        if (grant_sel) begin
                            we_l    <= bus.we1;
                            addr_l  <= bus.addr1;
                            wdata_l <= bus.wdata1;
                        end else begin
                            we_l    <= bus.we0;
                            addr_l  <= bus.addr0;
                            wdata_l <= bus.wdata0;
                        end
                    end
                end
                ISSUE: begin
                    cnt <= LAT;
                end
                WAIT: begin
                    cnt <= cnt - 3'd1;
                    // the memory presents read data on the last wait cycle
                    if (cnt == 3'd1) begin
                        if (sel) begin
                            rdata1_q <= bus.mem_rdata;
                        end else begin
                            rdata0_q <= bus.mem_rdata;
                        end
                    end
                end
                DONE: begin
`ifdef SC_DMEM_ARB_LOCK_EN
                    // keep ownership only while requested and under the run limit
                    if (lock_sel && ((lock_cnt + 8'd1) < LMAX)) begin
                        locked   <= 1'b1;
                        lock_cnt <= lock_cnt + 8'd1;
                    end else begin
                        locked   <= 1'b0;
                        lock_cnt <= '0;
                        prio     <= ~sel;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    // outputs decoded from state and latches
    always_comb begin
        bus.mem_en    = (state == ISSUE);
        bus.mem_we    = (state == ISSUE) && we_l;
        bus.mem_addr  = addr_l;
        bus.mem_wdata = wdata_l;
        bus.ack0      = (state == DONE) && !sel;
        bus.ack1      = (state == DONE) && sel;
        bus.rdata0    = rdata0_q;
        bus.rdata1    = rdata1_q;
        bus.busy      = (state != IDLE);
        bus.owner     = sel;
    end
endmodule

// File: tb/tb_sc_dmem_arbiter.sv
// tb/tb_sc_dmem_arbiter.sv - directed self-checking bench for sc_dmem_arbiter
module tb_sc_dmem_arbiter;
    localparam int LAT  = 3;
    localparam int LMAX = 2;

    logic clock;
    logic resetn;
    int   n_checks;
    int   n_fail;

    sc_dmem_arbiter_if #(.AW(32), .DW(32)) bus ();

    sc_dmem_arbiter #(
        .AW(32), .DW(32), .MEM_LAT(LAT), .LOCK_MAX(LMAX)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // memory model: writes land on the strobe edge, reads appear LAT cycles after the strobe
    logic [31:0] mem [0:255];
    logic [7:0]  pend;
    logic [7:0]  paddr [0:7];

    always @(posedge clock) begin
        if (!resetn) begin
            pend <= '0;
        end else begin
            pend <= {pend[6:0], bus.mem_en && !bus.mem_we};
        end
        if (bus.mem_en && bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
        paddr[0] <= bus.mem_addr[9:2];
        for (int i = 1; i < 8; i++) paddr[i] <= paddr[i-1];
    end

    assign bus.mem_rdata = pend[LAT-1] ? mem[paddr[LAT-1]] : 32'hDEAD_BEEF;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // one transaction on a port; returns cycles from request to ack and the port's rdata at ack
    task automatic do_txn(input string tag, input logic port, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, output int lat, output logic [31:0] rd);
        int stray;
        @(negedge clock);
        if (port) begin
            bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata;
        end else begin
            bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata;
        end
        lat   = -1;
        rd    = '0;
        stray = 0;
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            @(negedge clock);
            if (port ? bus.ack0 : bus.ack1) stray++;
            if (port ? bus.ack1 : bus.ack0) begin
                lat = k;
                rd  = port ? bus.rdata1 : bus.rdata0;
            end
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        check({tag, "_stray_ack"}, stray, 0);
    endtask

    int          lat;
    logic [31:0] rd;
    int          ng;
    int          dbl;
    int          acks;
    logic        gr [0:5];
    logic        ow [0:5];
    logic        exp_gr [0:5];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        resetn   = 1'b0;
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.we0 = 1'b0; bus.we1 = 1'b0;
        bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
        bus.lock0 = 1'b0; bus.lock1 = 1'b0;
        repeat (2) @(negedge clock);

        // reset state
        check("rst_busy", bus.busy, 0);
        check("rst_mem_en", bus.mem_en, 0);
        check("rst_acks", {bus.ack0, bus.ack1}, 0);
        check("rst_owner", bus.owner, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_rdata", {bus.rdata0, bus.rdata1}, 0);
        resetn = 1'b1;

        // T1: port 0 write, cycle-accurate
        @(negedge clock);
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 32'h10; bus.wdata0 = 32'hA5A5_A5A5;
        check("t1_c0_busy", bus.busy, 0);
        @(negedge clock);
        check("t1_c1_mem_en_we", {bus.mem_en, bus.mem_we}, 2'b11);
        check("t1_c1_mem_addr", bus.mem_addr, 32'h10);
        check("t1_c1_mem_wdata", bus.mem_wdata, 32'hA5A5_A5A5);
        check("t1_c1_busy_ack", {bus.busy, bus.ack0}, 2'b10);
        @(negedge clock);
        check("t1_c2_ack0", {bus.ack0, bus.ack1}, 2'b10);
        check("t1_c2_busy_mem_en", {bus.busy, bus.mem_en, bus.mem_we}, 3'b100);
        bus.req0 = 1'b0;
        @(negedge clock);
        check("t1_c3_idle", {bus.busy, bus.ack0, bus.mem_en, bus.mem_we}, 4'b0000);
        check("t1_c3_addr_held", bus.mem_addr, 32'h10);
        check("t1_mem_written", mem[4], 32'hA5A5_A5A5);

        // T2: write then read back through both ports with MEM_LAT=3
        do_txn("t2w", 1'b1, 1'b1, 32'h20, 32'h1234_5678, lat, rd);
        check("t2w_lat", lat, 2);
        check("t2w_rdata1_untouched", bus.rdata1, 0);
        do_txn("t2r0", 1'b0, 1'b0, 32'h10, 32'h0, lat, rd);
        check("t2r0_lat", lat, 5);
        check("t2r0_rdata", rd, 32'hA5A5_A5A5);
        do_txn("t2r1", 1'b1, 1'b0, 32'h20, 32'h0, lat, rd);
        check("t2r1_lat", lat, 5);
        check("t2r1_rdata", rd, 32'h1234_5678);
        check("t2_rdata0_held", bus.rdata0, 32'hA5A5_A5A5);

        // T3: both masters request continuously
        @(negedge clock);
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 32'h40; bus.wdata0 = 32'h0000_0040;
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 32'h44; bus.wdata1 = 32'h0000_0044;
        ng = 0; dbl = 0;
        for (int c = 0; c < 100 && ng < 4; c++) begin
            @(negedge clock);
            if (bus.ack0 && bus.ack1) dbl++;
            if (bus.ack0 || bus.ack1) begin
                gr[ng] = bus.ack1;
                ow[ng] = bus.owner;
                ng++;
            end
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        check("t3_count", ng, 4);
        check("t3_double_ack", dbl, 0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t3_grant%0d", i), gr[i], i % 2);
            check($sformatf("t3_owner%0d", i), ow[i], i % 2);
        end

        // T4: reset during the wait phase of a read
        @(negedge clock);
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'h10;
        @(negedge clock);
        @(negedge clock);
        check("t4_in_wait_busy", bus.busy, 1);
        #1 resetn = 1'b0;
        #1;
        check("t4_abort_busy_en", {bus.busy, bus.mem_en, bus.mem_we}, 0);
        check("t4_abort_ack_owner", {bus.ack0, bus.ack1, bus.owner}, 0);
        check("t4_abort_mem_addr", bus.mem_addr, 0);
        check("t4_abort_rdata", {bus.rdata0, bus.rdata1}, 0);
        bus.req0 = 1'b0;
        acks = 0;
        repeat (3) begin
            @(negedge clock);
            if (bus.ack0 || bus.ack1) acks++;
        end
        resetn = 1'b1;
        repeat (2) begin
            @(negedge clock);
            if (bus.ack0 || bus.ack1) acks++;
        end
        check("t4_no_ack", acks, 0);
        do_txn("t4r", 1'b0, 1'b0, 32'h20, 32'h0, lat, rd);
        check("t4r_lat", lat, 5);
        check("t4r_rdata", rd, 32'h1234_5678);

        // T5/T6: master 0 asks to lock while master 1 contends
        @(negedge clock);
        resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
`ifdef SC_DMEM_ARB_LOCK_EN
        exp_gr[0] = 0; exp_gr[1] = 0; exp_gr[2] = 1; exp_gr[3] = 0; exp_gr[4] = 0; exp_gr[5] = 1;
`else
        exp_gr[0] = 0; exp_gr[1] = 1; exp_gr[2] = 0; exp_gr[3] = 1; exp_gr[4] = 0; exp_gr[5] = 1;
`endif
        @(negedge clock);
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 32'h50; bus.wdata0 = 32'h0000_0050; bus.lock0 = 1'b1;
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 32'h54; bus.wdata1 = 32'h0000_0054;
        ng = 0; dbl = 0;
        for (int c = 0; c < 100 && ng < 6; c++) begin
            @(negedge clock);
            if (bus.ack0 && bus.ack1) dbl++;
            if (bus.ack0 || bus.ack1) begin
                gr[ng] = bus.ack1;
                ng++;
            end
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.lock0 = 1'b0;
        check("t5_count", ng, 6);
        check("t5_double_ack", dbl, 0);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("t5_grant%0d", i), gr[i], exp_gr[i]);
        end

        repeat (3) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
